// File: rtl/gate_stim_gen_if.sv
// gate_stim_gen_if: control and stimulus bundle for gate_stim_gen.
//   master : sequencer/bench side, drives start and the run configuration,
//            observes the stimulus and the handshake status.
//   slave  : the generator itself.
// Signals:
//   start, mode, num_vec, hold_cyc : run request and configuration
//   a, b                           : gate-under-test inputs
//   vec_valid, vec_idx             : new-vector pulse and current vector index
//   busy, done                     : run in progress / end-of-run pulse
interface gate_stim_gen_if #(
  parameter int CNT_W  = 8,
  parameter int HOLD_W = 4
);
  logic              start;
  logic              mode;
  logic [CNT_W-1:0]  num_vec;
  logic [HOLD_W-1:0] hold_cyc;
  logic              a;
  logic              b;
  logic              vec_valid;
  logic [CNT_W-1:0]  vec_idx;
  logic              busy;
  logic              done;

  modport master (
    output start, mode, num_vec, hold_cyc,
    input  a, b, vec_valid, vec_idx, busy, done
  );

  modport slave (
    input  start, mode, num_vec, hold_cyc,
    output a, b, vec_valid, vec_idx, busy, done
  );
endinterface

// File: rtl/gate_stim_gen.sv
// gate_stim_gen: clocked, repeatable stimulus source for a 2-input gate.
// Emits num_vec vectors on {a,b}, each held for hold_cyc+1 cycles, either
// counting (00,01,10,11,...) or from a free-running 16-bit LFSR.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : gate_stim_gen_if.slave (start/config in, a/b/status out)
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after a run
// ARM   | config latched, one launch cycle before the first vector
// DRIVE | first cycle of a vector on a/b (vec_valid high)
// HOLD  | vector held, hold counter running down to 1
module gate_stim_gen #(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
  parameter int                CNT_W  = 8,
  parameter int                HOLD_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  gate_stim_gen_if.slave  bus
);

  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

  typedef enum logic [1:0] {IDLE, ARM, DRIVE, HOLD} state_t;

  state_t            state, state_nx;
  logic              mode_q, mode_nx;
  logic [CNT_W-1:0]  num_q, num_nx;
  logic [HOLD_W-1:0] hold_q, hold_nx;
  logic [HOLD_W-1:0] hcnt, hcnt_nx;
  logic [LFSR_W-1:0] lfsr, lfsr_nx;
  logic              a_q, a_nx, b_q, b_nx;
  logic              vv_q, vv_nx, busy_q, busy_nx, done_q, done_nx;
  logic [CNT_W-1:0]  idx_q, idx_nx;
  logic              load, finish, last, fb;
  logic [CNT_W-1:0]  load_idx;

  assign fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign last = (idx_q == num_q - 1'b1);

  always_comb begin
    state_nx = state;
    mode_nx  = mode_q;
    num_nx   = num_q;
    hold_nx  = hold_q;
    hcnt_nx  = hcnt;
    lfsr_nx  = lfsr;
    a_nx     = a_q;
    b_nx     = b_q;
    vv_nx    = 1'b0;
    busy_nx  = busy_q;
    done_nx  = 1'b0;
    idx_nx   = idx_q;
    load     = 1'b0;
    finish   = 1'b0;
    load_idx = idx_q + 1'b1;

    case (state)
      IDLE: begin
        if (bus.start) begin
          mode_nx  = bus.mode;
          num_nx   = bus.num_vec;
          hold_nx  = bus.hold_cyc;
          idx_nx   = '0;
          state_nx = ARM;
        end
      end
      ARM: begin
        if (num_q == '0) begin
          finish = 1'b1;
        end else begin
          load     = 1'b1;
          load_idx = '0;
        end
      end
      DRIVE: begin
        if (hold_q != '0) begin
          state_nx = HOLD;
          hcnt_nx  = hold_q;
        end else if (last) begin
          finish = 1'b1;
        end else begin
          load = 1'b1;
        end
      end
      HOLD: begin
        if (hcnt == HOLD_W'(1)) begin
          hcnt_nx = '0;
          if (last) finish = 1'b1;
          else      load   = 1'b1;
        end else begin
          hcnt_nx = hcnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (finish) begin
      state_nx = IDLE;
      busy_nx  = 1'b0;
      done_nx  = 1'b1;
    end

    // Outputs are registered, so the vector chosen here appears on the
    // edge that enters DRIVE.
    if (load) begin
      state_nx = DRIVE;
      vv_nx    = 1'b1;
      busy_nx  = 1'b1;
      idx_nx   = load_idx;
      if (mode_q) begin
        {a_nx, b_nx} = lfsr[1:0];
        lfsr_nx      = {lfsr[LFSR_W-2:0], fb};
      end else begin
        {a_nx, b_nx} = load_idx[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mode_q <= 1'b0;
      num_q  <= '0;
      hold_q <= '0;
      hcnt   <= '0;
      lfsr   <= SEED_EFF;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      vv_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      state  <= state_nx;
      mode_q <= mode_nx;
      num_q  <= num_nx;
      hold_q <= hold_nx;
      hcnt   <= hcnt_nx;
      lfsr   <= lfsr_nx;
      a_q    <= a_nx;
      b_q    <= b_nx;
      vv_q   <= vv_nx;
      busy_q <= busy_nx;
      done_q <= done_nx;
      idx_q  <= idx_nx;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.vec_valid = vv_q;
  assign bus.vec_idx   = idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_gate_stim_gen.sv
// tb_gate_stim_gen: scoreboard bench for gate_stim_gen. Stimulus tasks push
// expected vectors, done events and busy windows; a negedge monitor pops and
// compares whenever the DUT presents vec_valid or done.
module tb_gate_stim_gen;
  localparam int CNT_W  = 8;
  localparam int HOLD_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  gate_stim_gen_if #(.CNT_W(CNT_W), .HOLD_W(HOLD_W)) bus ();

  gate_stim_gen #(
    .LFSR_W(16), .SEED(16'hACE1), .CNT_W(CNT_W), .HOLD_W(HOLD_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [1:0] ab; int idx; } vec_t;
  typedef struct { int cyc; logic [1:0] ab; } done_t;
  typedef struct { int lo; int hi; } win_t;

  vec_t  vec_q[$];
  done_t done_q[$];
  win_t  win_q[$];

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  logic [1:0] held_ab = 2'b00;
  logic [1:0] model_ab = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin : monitor
    vec_t  v;
    done_t d;
    logic  be;
    if (mon_en && rst_n) begin
      while (win_q.size() > 0 && cyc > win_q[0].hi) void'(win_q.pop_front());
      be = (win_q.size() > 0 && cyc >= win_q[0].lo);
      chk("busy", bus.busy, be);
      if (bus.vec_valid) begin
        if (vec_q.size() == 0) begin
          chk("spurious_vec_valid", bus.vec_valid, 1'b0);
        end else begin
          v = vec_q.pop_front();
          chk("vec_cycle", cyc, v.cyc);
          chk("vec_ab", {bus.a, bus.b}, v.ab);
          chk("vec_idx", bus.vec_idx, v.idx);
          held_ab = v.ab;
        end
      end else if (bus.busy) begin
        chk("hold_ab", {bus.a, bus.b}, held_ab);
      end
      if (bus.done) begin
        if (done_q.size() == 0) begin
          chk("spurious_done", bus.done, 1'b0);
        end else begin
          d = done_q.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("done_ab", {bus.a, bus.b}, d.ab);
        end
      end
    end
  end

  // Issue one run; start is sampled at edge n0 (no earlier than at_cyc).
  task automatic run(input bit m, input int num, input int hold,
                     input logic [1:0] rnd[$], input int at_cyc, output int done_at);
    int n0;
    logic [1:0] ab;
    @(posedge clk); #1;
    while (cyc < at_cyc - 1) begin @(posedge clk); #1; end
    bus.start    = 1'b1;
    bus.mode     = m;
    bus.num_vec  = CNT_W'(num);
    bus.hold_cyc = HOLD_W'(hold);
    n0 = cyc + 1;
    for (int k = 0; k < num; k++) begin
      ab = m ? rnd[k] : k[1:0];
      vec_q.push_back('{n0 + 1 + k * (hold + 1), ab, k});
      model_ab = ab;
    end
    if (num > 0) win_q.push_back('{n0 + 1, n0 + num * (hold + 1)});
    done_at = n0 + 1 + num * (hold + 1);
    done_q.push_back('{done_at, model_ab});
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.mode     = ~m;
    bus.num_vec  = '1;
    bus.hold_cyc = '1;
  endtask

  task automatic drain();
    int t = 0;
    while ((vec_q.size() + done_q.size()) != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", vec_q.size() + done_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] none[$];
    logic [1:0] q[$];
    int d0, d1;
    int t;
    bit found;

    bus.start = 1'b0; bus.mode = 1'b0; bus.num_vec = '0; bus.hold_cyc = '0;
    #12;
    chk("rst_a", bus.a, 1'b0);
    chk("rst_b", bus.b, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_vec_valid", bus.vec_valid, 1'b0);
    chk("rst_vec_idx", bus.vec_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Exhaustive, no hold
    run(1'b0, 6, 0, none, 0, d0);
    drain();
    // Exhaustive, long hold
    run(1'b0, 4, 9, none, 0, d0);
    drain();
    // Random: ACE1 -> 59C3 -> B387, then continue from 670F -> CE1E
    q.delete(); q.push_back(2'b01); q.push_back(2'b11); q.push_back(2'b11);
    run(1'b1, 3, 0, q, 0, d0);
    drain();
    q.delete(); q.push_back(2'b11); q.push_back(2'b10);
    run(1'b1, 2, 0, q, 0, d0);
    drain();
    // Zero-length run
    run(1'b0, 0, 3, none, 0, d0);
    drain();
    // Back-to-back: second start during the done cycle; LFSR 9C3C -> 3879
    run(1'b0, 2, 1, none, 0, d0);
    q.delete(); q.push_back(2'b00); q.push_back(2'b01);
    run(1'b1, 2, 0, q, d0 + 1, d1);
    drain();
    // Start pulse mid-run is ignored
    run(1'b0, 5, 2, none, 0, d0);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.mode = 1'b1; bus.num_vec = 8'd1; bus.hold_cyc = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    drain();

    // Asynchronous reset mid-run at vector 3, then random run restarts at SEED
    mon_en = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mode = 1'b0; bus.num_vec = 8'd6; bus.hold_cyc = 4'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    found = 1'b0;
    t = 0;
    while (!found && t < 200) begin
      @(negedge clk);
      found = bus.vec_valid && (bus.vec_idx == 8'd3);
      t++;
    end
    chk("reach_vec3", found, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_a", bus.a, 1'b0);
    chk("arst_b", bus.b, 1'b0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_vec_valid", bus.vec_valid, 1'b0);
    chk("arst_vec_idx", bus.vec_idx, 0);
    chk("arst_done", bus.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_ab = 2'b00;
    held_ab = 2'b00;
    vec_q.delete(); done_q.delete(); win_q.delete();
    mon_en = 1'b1;
    q.delete(); q.push_back(2'b01); q.push_back(2'b11);
    run(1'b1, 2, 0, q, 0, d0);
    drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gate_stim_gen.md
Name: gate_stim_gen

Overview:
Synthesizable stimulus generator that drives the two inputs (a, b) of a 2-input gate under test, such as and_g_demux, one vector per programmable hold window. It sits directly upstream of the gate and replaces free-running $random stimulus with a repeatable, clocked source. It supports exhaustive (counting) and pseudo-random (LFSR) modes, with a start/busy/done handshake toward the controlling bench or sequencer.

Parameters:
LFSR_W, 16, LFSR width; taps fixed for 16 bits (x^16+x^14+x^13+x^11+1).
SEED, 16'hACE1, LFSR reset value. SEED==0 is replaced by 1.
CNT_W, 8, width of num_vec and vec_idx.
HOLD_W, 4, width of hold_cyc.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  run request; sampled only in IDLE
mode  in  1  0 = exhaustive, 1 = LFSR random; latched at start
num_vec  in  CNT_W  number of vectors to emit; latched at start
hold_cyc  in  HOLD_W  extra cycles each vector is held; latched at start
a  out  1  gate input A (registered)
b  out  1  gate input B (registered)
vec_valid  out  1  one-cycle pulse on the first cycle a new vector is on a/b
vec_idx  out  CNT_W  index of the current vector, 0..num_vec-1
busy  out  1  high while vectors are being driven
done  out  1  one-cycle pulse at end of run

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset values (applied immediately, also mid-run): a=0, b=0, vec_valid=0, vec_idx=0, busy=0, done=0, lfsr=SEED, state=IDLE, hold counter=0.
- States:
  - IDLE: start=1 latches mode, num_vec and hold_cyc. If num_vec==0, go to IDLE and pulse done on the next edge, with busy never asserted. Otherwise go to DRIVE.
  - DRIVE: one cycle. Loads a new vector, pulses vec_valid and sets busy=1. If hold_cyc>0, go to HOLD; otherwise go to the next DRIVE, or finish after the last vector.
  - HOLD: counts hold_cyc cycles with a/b stable, then goes to the next DRIVE or finishes.
- Finish: transition to IDLE with busy=0, done=1 for one cycle, and a/b retaining the last vector.
- Timing: start sampled high at edge N means vector k appears at edge N+1+k*(hold_cyc+1), and done asserts at edge N+1+num_vec*(hold_cyc+1). Each vector occupies exactly hold_cyc+1 cycles.
- Exhaustive mode: {a,b}=vec_idx[1:0], giving the sequence 00, 01, 10, 11, 00, and so on (wrap every 4).
- Random mode: {a,b}=lfsr[1:0] at the DRIVE cycle, and the LFSR advances once per vector in that same cycle.
  - Advance rule: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - The LFSR is not reloaded by start; successive runs continue the sequence. Only rst_n restores SEED.
- vec_idx increments at each DRIVE after the first and resets to 0 at start. Maximum num_vec is 2^CNT_W-1.
- start while busy is ignored, with no effect on the latched configuration.
- start during the done cycle (state is IDLE) is accepted, so back-to-back runs are allowed.
- Config inputs changing mid-run have no effect.

Test Plan:
1. rst_n=0 asserted asynchronously mid-cycle -> a=b=0, busy=0, done=0, vec_valid=0 immediately, with no clock edge needed.
2. mode=0, num_vec=6, hold_cyc=0, start at edge N -> {a,b}=00,01,10,11,00,01 on edges N+1..N+6; vec_valid high each of those cycles; busy high N+1..N+6; done pulse at N+7 with {a,b}=01 held.
3. mode=0, num_vec=4, hold_cyc=9 -> each vector stable 10 cycles; vec_valid pulses at N+1, N+11, N+21, N+31; done at N+41.
4. mode=1, SEED=16'hACE1, num_vec=3, hold_cyc=0 -> {a,b}=01, 11, 11 (lfsr ACE1 -> 59C3 -> B387). A second run continues from lfsr=670F (next vector 11).
5. num_vec=0, start -> done pulse at N+1; busy and vec_valid never assert; a/b unchanged.
6. Pulse start again during a run (ignored, same vector count). Assert rst_n low at vector 3, then rerun mode=1 -> first vector is 01 again (LFSR back at SEED).
